sat_narrow: RTL

Pipelined narrowing macrocell, the inverse of the sign/zero-extension cell: reduces an `inwidth`-bit value to `outwidth` bits by saturation or wrap. Streams through a 2-stage valid/ready pipeline and flags every out-of-range value with a sticky flag and a saturating event counter. Sits at the output of wide accumulators and datapaths, before narrow stores and ports.

---
 rtl/sat_narrow_pkg.sv | 19 +
 rtl/sat_narrow_chk.sv | 30 +++
 rtl/sat_narrow.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sat_narrow_pkg.sv
// Shared constants and saturation-limit helpers for the narrowing macrocell.
// Helpers return 64-bit values; callers slice to the width they need.
package sat_narrow_pkg;

    localparam int SAT_NARROW_LAT = 2;

    function automatic logic [63:0] max_signed(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_signed(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] max_unsigned(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/sat_narrow_chk.sv
// Range check: flags values not representable in outwidth bits and reports
// which saturation limit applies (sign bit is forced to 0 in unsigned mode).
module narrow_chk #(
    parameter int inwidth  = 32,
    parameter int outwidth = 16
) (
    input  logic [inwidth-1:0] i0,
    input  logic               signedflag,
    output logic               o_ovf,
    output logic               o_sign
);

    logic [inwidth-outwidth:0] w_top;
    logic                      w_sovf;
    logic                      w_uovf;

    // Signed values fit only when every bit from the output MSB upward is a copy of the sign.
    assign w_top  = i0[inwidth-1:outwidth-1];
    assign w_sovf = !((&w_top) || !(|w_top));

    if (inwidth > outwidth) begin : g_uchk
        assign w_uovf = |i0[inwidth-1:outwidth];
    end else begin : g_nouchk
        assign w_uovf = 1'b0;
    end

    assign o_ovf  = signedflag ? w_sovf : w_uovf;
    assign o_sign = signedflag & i0[inwidth-1];

endmodule

// File: rtl/sat_narrow.sv
// Two-stage elastic narrowing pipeline: range check in stage 1, saturate/wrap mux
// into stage 2, plus sticky overflow flag and saturating overflow event counter.
module sat_narrow
    import sat_narrow_pkg::*;
#(
    parameter int inwidth    = 32,
    parameter int outwidth   = 16,
    parameter bit signedflag = 1'b0,
    parameter bit satflag    = 1'b1,
    parameter int cntwidth   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [inwidth-1:0]  i0,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [outwidth-1:0] o0,
    output logic                o_ovf,
    output logic                ovf_sticky,
    output logic [cntwidth-1:0] ovf_count,
    input  logic                clr
);

    if (inwidth < outwidth) begin : g_bad_width
        $fatal(1, "sat_narrow: inwidth (%0d) must be >= outwidth (%0d)", inwidth, outwidth);
    end

    localparam logic [outwidth-1:0] SAT_MAX =
        outwidth'(signedflag ? max_signed(outwidth) : max_unsigned(outwidth));
    localparam logic [outwidth-1:0] SAT_MIN = outwidth'(min_signed(outwidth));

    logic                w_chk_ovf;
    logic                w_chk_sign;
    logic                w_s1_ld;
    logic                w_s2_ld;
    logic                w_evt;
    logic [outwidth-1:0] w_s2_nxt;

    logic                r_s1_vld;
    logic [outwidth-1:0] r_s1_dat;
    logic                r_s1_ovf;
    logic                r_s1_sign;
    logic                r_s2_vld;
    logic [outwidth-1:0] r_s2_dat;
    logic                r_s2_ovf;
    logic                r_sticky;
    logic [cntwidth-1:0] r_cnt;

    narrow_chk #(
        .inwidth  (inwidth),
        .outwidth (outwidth)
    ) u_chk (
        .i0         (i0),
        .signedflag (signedflag),
        .o_ovf      (w_chk_ovf),
        .o_sign     (w_chk_sign)
    );

    // No skid buffer: a full pipe frees a slot in the same cycle the consumer takes a word.
    assign w_s2_ld = !r_s2_vld || o_ready;
    assign w_s1_ld = !r_s1_vld || w_s2_ld;
    assign i_ready = w_s1_ld;
    assign w_evt   = i_valid && w_s1_ld && w_chk_ovf;

    always_comb begin
        w_s2_nxt = r_s1_dat;
        if (satflag && r_s1_ovf) begin
            w_s2_nxt = r_s1_sign ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_ovf  <= 1'b0;
            r_s1_sign <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_vld <= i_valid;
            if (i_valid) begin
                r_s1_dat  <= i0[outwidth-1:0];
                r_s1_ovf  <= w_chk_ovf;
                r_s1_sign <= w_chk_sign;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_ovf <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat <= w_s2_nxt;
                r_s2_ovf <= r_s1_ovf;
            end
        end
    end

    // A clear coinciding with an event leaves exactly that one event recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_sticky <= w_evt;
            r_cnt    <= w_evt ? cntwidth'(1) : '0;
        end else if (w_evt) begin
            r_sticky <= 1'b1;
            if (!(&r_cnt)) begin
                r_cnt <= r_cnt + cntwidth'(1);
            end
        end
    end

    assign o_valid    = r_s2_vld;
    assign o0         = r_s2_dat;
    assign o_ovf      = r_s2_ovf;
    assign ovf_sticky = r_sticky;
    assign ovf_count  = r_cnt;

endmodule
